// File: rtl/scalar_pkg.sv
// rtl/scalar_pkg.sv - shared constants and types for the scalar writeback path
//
// Purpose: register-bank geometry and the writeback request record shared by
// the writeback arbiter and its round-robin helper.
// Contents: NREG, RW, DW constants; reg_idx_t, word_t, wb_req_t types.
package scalar_pkg;

   localparam int NREG = 8;
   localparam int RW   = 3;
   localparam int DW   = 32;

   typedef logic [RW-1:0] reg_idx_t;
   typedef logic [DW-1:0] word_t;

   typedef struct packed {
      reg_idx_t rd;
      word_t    data;
   } wb_req_t;

endpackage

// File: rtl/scalar_wb_arbiter_rr_arbiter.sv
// rtl/scalar_wb_arbiter_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first asserted request scanning from ptr upward,
// wrapping modulo N.
// Ports:
//   req      in   N      request vector
//   ptr      in   IW     highest-priority index for this cycle
//   gnt      out  N      one-hot grant, zero when no request
//   gnt_idx  out  IW     index of the granted request, zero when none
module rr_arbiter
   import scalar_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         // Candidate index for scan step k, wrapped into 0..N-1.
         idx = IW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
   end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// rtl/scalar_wb_arbiter.sv - round-robin writeback arbiter with pending-write scoreboard
//
// Purpose: shares the single write port of the scalar register bank among
// NREQ requesters, registers the winner into a one-cycle write stage, and
// tracks destinations with writes still in flight for hazard checks.
// Ports:
//   clk, rst                        clock, async active-high reset
//   req_valid/req_ready             per-requester handshake (ready one-hot)
//   req_rd/req_data                 packed per-requester destination/data
//   rf_we/rf_rd/rf_wdata/rf_src     registered bank write port + source index
//   resv_valid/resv_rd              issue-side destination reservation
//   chk_rs1/chk_rs2                 sources to hazard-check
//   rs1_busy/rs2_busy/pending       scoreboard read-outs
module scalar_wb_arbiter
   import scalar_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int NREG = scalar_pkg::NREG,
   parameter int RW   = scalar_pkg::RW,
   parameter int DW   = scalar_pkg::DW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*RW-1:0]      req_rd,
   input  logic [NREQ*DW-1:0]      req_data,
   output logic                    rf_we,
   output logic [RW-1:0]           rf_rd,
   output logic [DW-1:0]           rf_wdata,
   output logic [$clog2(NREQ)-1:0] rf_src,
   input  logic                    resv_valid,
   input  logic [RW-1:0]           resv_rd,
   input  logic [RW-1:0]           chk_rs1,
   input  logic [RW-1:0]           chk_rs2,
   output logic                    rs1_busy,
   output logic                    rs2_busy,
   output logic [NREG-1:0]         pending
);

   localparam int SW = $clog2(NREQ);

   wb_req_t         req_a [NREQ];
   logic [NREQ-1:0] gnt;
   logic [SW-1:0]   gnt_idx;

   logic            rf_we_q;
   logic [RW-1:0]   rf_rd_q;
   logic [DW-1:0]   rf_wdata_q;
   logic [SW-1:0]   rf_src_q;
   logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NREG-1:0] pending_q, pending_d;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign req_a[i].rd   = req_rd[i*RW +: RW];
      assign req_a[i].data = req_data[i*DW +: DW];
   end

   rr_arbiter #(.N(NREQ), .IW(SW)) u_rr_arbiter (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // No grants while reset is held, even though the arbiter itself is comb.
   assign req_ready = rst ? '0 : gnt;

   assign rr_ptr_d = (gnt_idx == SW'(NREQ - 1)) ? '0 : gnt_idx + SW'(1);

   // Commit clears first, then a reservation of the same index re-sets it:
   // the reservation belongs to a newer writer that is still in flight.
   always_comb begin
      pending_d = pending_q;
      if (rf_we_q)
         pending_d[rf_rd_q] = 1'b0;
      if (resv_valid)
         pending_d[resv_rd] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
         rf_src_q   <= '0;
         rr_ptr_q   <= '0;
         pending_q  <= '0;
      end else begin
         rf_we_q   <= |gnt;
         pending_q <= pending_d;
         if (|gnt) begin
            rf_rd_q    <= req_a[gnt_idx].rd;
            rf_wdata_q <= req_a[gnt_idx].data;
            rf_src_q   <= gnt_idx;
            rr_ptr_q   <= rr_ptr_d;
         end
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;
   assign rf_src   = rf_src_q;
   assign pending  = pending_q;

   // Read of the registered vector only; no bypass from this cycle's commit.
   assign rs1_busy = pending_q[chk_rs1];
   assign rs2_busy = pending_q[chk_rs2];

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// tb/tb_scalar_wb_arbiter.sv - scoreboard bench for scalar_wb_arbiter
module tb_scalar_wb_arbiter;

   localparam int NREQ = 3;
   localparam int NREG = 8;
   localparam int RW   = 3;
   localparam int DW   = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*RW-1:0]  req_rd;
   logic [NREQ*DW-1:0]  req_data;
   logic                rf_we;
   logic [RW-1:0]       rf_rd;
   logic [DW-1:0]       rf_wdata;
   logic [1:0]          rf_src;
   logic                resv_valid;
   logic [RW-1:0]       resv_rd;
   logic [RW-1:0]       chk_rs1;
   logic [RW-1:0]       chk_rs2;
   logic                rs1_busy;
   logic                rs2_busy;
   logic [NREG-1:0]     pending;

   always #5 clk = ~clk;

   scalar_wb_arbiter #(.NREQ(NREQ), .NREG(NREG), .RW(RW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rd     (req_rd),
      .req_data   (req_data),
      .rf_we      (rf_we),
      .rf_rd      (rf_rd),
      .rf_wdata   (rf_wdata),
      .rf_src     (rf_src),
      .resv_valid (resv_valid),
      .resv_rd    (resv_rd),
      .chk_rs1    (chk_rs1),
      .chk_rs2    (chk_rs2),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .pending    (pending)
   );

   typedef struct {
      int          src;
      int          rd;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         wlog[$];
   wr_t         mon_e, mon_o;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] dut_bank [NREG];
   logic [31:0] mdl_bank [NREG];

   // reference model state
   int          m_ptr;
   bit          m_pend [NREG];
   bit          infl_v;
   int          infl_rd;

   // stimulus for the next step
   logic [2:0]  s_valid;
   int          s_rd [NREQ];
   logic [31:0] s_data [NREQ];
   bit          s_rv;
   int          s_rr, s_c1, s_c2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pend_vec();
      logic [7:0] v;
      for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic set_idle();
      s_valid = 3'b000;
      s_rv    = 1'b0;
   endtask

   // Monitor: every bank write pops one expected write from the scoreboard.
   always @(negedge clk) begin
      if (rst === 1'b0 && rf_we === 1'b1) begin
         mon_o.src  = int'(rf_src);
         mon_o.rd   = int'(rf_rd);
         mon_o.data = rf_wdata;
         wlog.push_back(mon_o);
         dut_bank[rf_rd] = rf_wdata;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual src=%0d rd=%0d data=%h required=no write",
                     mon_o.src, mon_o.rd, mon_o.data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_src", mon_o.src, mon_e.src);
            chk("wb_rd", mon_o.rd, mon_e.rd);
            chk("wb_data", mon_o.data, mon_e.data);
         end
      end
   end

   // One cycle: drive, check grant against the model, advance the model at the edge.
   task automatic step();
      int         w;
      logic [2:0] exp_ready;
      @(negedge clk);
      req_valid  = s_valid;
      req_rd     = {3'(s_rd[2]), 3'(s_rd[1]), 3'(s_rd[0])};
      req_data   = {s_data[2], s_data[1], s_data[0]};
      resv_valid = s_rv;
      resv_rd    = 3'(s_rr);
      chk_rs1    = 3'(s_c1);
      chk_rs2    = 3'(s_c2);
      #1;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = (m_ptr + k) % NREQ;
         if (w < 0 && s_valid[c]) w = c;
      end
      exp_ready = (w >= 0) ? 3'(1 << w) : 3'b000;
      chk("req_ready", req_ready, exp_ready);
      if (w >= 0) begin
         exp_q.push_back('{w, s_rd[w], s_data[w]});
         mdl_bank[s_rd[w]] = s_data[w];
      end
      @(posedge clk);
      #1;
      if (infl_v) m_pend[infl_rd] = 1'b0;
      if (s_rv) m_pend[s_rr] = 1'b1;
      infl_v = (w >= 0);
      if (w >= 0) begin
         infl_rd = s_rd[w];
         m_ptr   = (w + 1) % NREQ;
      end
      chk("pending", pending, pend_vec());
      chk("rs1_busy", rs1_busy, m_pend[s_c1]);
      chk("rs2_busy", rs2_busy, m_pend[s_c2]);
   endtask

   int base;
   int rr_exp [10] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};

   initial begin
      for (int i = 0; i < NREG; i++) begin
         dut_bank[i] = '0;
         mdl_bank[i] = '0;
         m_pend[i]   = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
         s_rd[i]   = 0;
         s_data[i] = '0;
      end
      m_ptr = 0; infl_v = 0; infl_rd = 0;
      s_rr = 0; s_c1 = 0; s_c2 = 0;
      set_idle();

      // power-on reset with all requesters asserting
      rst = 1'b1;
      req_valid = 3'b111; req_rd = '0; req_data = '0;
      resv_valid = 1'b0; resv_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", req_ready, 3'b000);
      chk("reset_we", rf_we, 1'b0);
      chk("reset_pending", pending, 8'h00);
      chk("reset_src", rf_src, 2'd0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 3'b000;

      // single request, one-cycle latency
      set_idle();
      s_valid = 3'b010; s_rd[1] = 5; s_data[1] = 32'hDEAD_BEEF;
      step();
      chk("single_we", rf_we, 1'b1);
      chk("single_rd", rf_rd, 3'd5);
      chk("single_data", rf_wdata, 32'hDEAD_BEEF);
      chk("single_src", rf_src, 2'd1);
      set_idle();
      step();
      chk("single_idle_we", rf_we, 1'b0);
      chk("single_bank", dut_bank[5], 32'hDEAD_BEEF);

      // align pointer to 0 via requester 2, then round-robin patterns
      s_valid = 3'b100; s_rd[2] = 7; s_data[2] = 32'h0000_0007;
      step();
      set_idle();
      step();
      base = wlog.size();
      for (int i = 0; i < NREQ; i++) begin
         s_rd[i] = i;
         s_data[i] = 32'h100 + i;
      end
      s_valid = 3'b111;
      repeat (6) step();
      s_valid = 3'b101;
      repeat (4) step();
      set_idle();
      step();
      chk("rr_count", wlog.size() - base, 10);
      for (int i = 0; i < 10; i++)
         if (base + i < wlog.size()) chk("rr_order", wlog[base + i].src, rr_exp[i]);

      // scoreboard set and clear
      set_idle();
      s_rv = 1'b1; s_rr = 3; s_c1 = 3; s_c2 = 0;
      step();
      chk("sb_pending_set", pending, 8'h08);
      chk("sb_rs1_busy", rs1_busy, 1'b1);
      chk("sb_rs2_busy", rs2_busy, 1'b0);
      set_idle();
      s_valid = 3'b100; s_rd[2] = 3; s_data[2] = 32'h3333_3333;
      step();
      chk("sb_pending_inflight", pending, 8'h08);
      set_idle();
      step();
      chk("sb_pending_clear", pending, 8'h00);
      chk("sb_rs1_free", rs1_busy, 1'b0);

      // set/clear collision on r6
      s_valid = 3'b100; s_rd[2] = 6; s_data[2] = 32'h6666_6666;
      step();
      set_idle();
      s_rv = 1'b1; s_rr = 6;
      step();
      chk("collide_set_wins", pending[6], 1'b1);
      set_idle();
      step();
      chk("collide_hold", pending[6], 1'b1);
      s_valid = 3'b100;
      step();
      set_idle();
      step();
      chk("collide_release", pending[6], 1'b0);

      // same destination from requesters 0 and 1, pointer at 0
      base = wlog.size();
      s_valid = 3'b011; s_rd[0] = 2; s_rd[1] = 2; s_data[0] = 32'd11; s_data[1] = 32'd22;
      step();
      s_valid = 3'b010;
      step();
      set_idle();
      step();
      step();
      chk("samerd_count", wlog.size() - base, 2);
      if (wlog.size() >= base + 2) begin
         chk("samerd_first", wlog[base].data, 32'd11);
         chk("samerd_second", wlog[base + 1].data, 32'd22);
      end
      chk("samerd_bank", dut_bank[2], 32'd22);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         s_valid = 3'($urandom_range(0, 7));
         for (int i = 0; i < NREQ; i++) begin
            s_rd[i]   = $urandom_range(0, NREG - 1);
            s_data[i] = $urandom;
         end
         s_rv = ($urandom_range(0, 3) == 0);
         s_rr = $urandom_range(0, NREG - 1);
         s_c1 = $urandom_range(0, NREG - 1);
         s_c2 = $urandom_range(0, NREG - 1);
         step();
      end
      set_idle();
      step();
      step();
      for (int i = 0; i < NREG; i++) chk("bank_final", dut_bank[i], mdl_bank[i]);
      chk("scoreboard_drained", exp_q.size(), 0);

      // asynchronous reset mid-cycle with a write in flight and pending set
      s_valid = 3'b111; s_rv = 1'b1; s_rr = 4;
      step();
      @(negedge clk);
      req_valid = 3'b111;
      resv_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_we", rf_we, 1'b0);
      chk("async_ready", req_ready, 3'b000);
      chk("async_pending", pending, 8'h00);
      exp_q.delete();
      m_ptr = 0; infl_v = 0;
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      @(posedge clk);
      #1;
      chk("async_hold_we", rf_we, 1'b0);
      chk("async_rd", rf_rd, 3'd0);
      chk("async_wdata", rf_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 3'b000;
      set_idle();
      s_valid = 3'b111;
      step();
      chk("post_reset_src", rf_src, 2'd0);
      set_idle();
      step();
      step();
      chk("final_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
